// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin register write arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } arb_state_t;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 16;

endpackage : arb_pkg

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester at or above ptr, wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            valid,
    output logic [PW-1:0]   winner,
    output logic [NREQ-1:0] gnt
);

    int idx;

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!valid && req[idx[PW-1:0]]) begin
                valid  = 1'b1;
                winner = idx[PW-1:0];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_gnt
            assign gnt[gi] = valid && (winner == PW'(gi));
        end
    endgenerate

endmodule : rr_pick

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting one-cycle writes into a shared register; one write per two cycles at most.
module reg_write_arbiter
    import arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata_in,
    output logic [NREQ-1:0]       ack,
    output logic                  reg_we,
    output logic [WIDTH-1:0]      reg_wdata,
    output logic                  busy,
    output logic [CNT_W-1:0]      write_count
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t        state_reg, state_next;
    logic [PW-1:0]     ptr_reg, ptr_next;
    logic [NREQ-1:0]   ack_reg, ack_next;
    logic              we_reg, we_next;
    logic [WIDTH-1:0]  wdata_reg, wdata_next;
    logic [CNT_W-1:0]  count_reg, count_next;

    logic              pick_valid;
    logic [PW-1:0]     pick_winner;
    logic [NREQ-1:0]   pick_gnt;
    logic [WIDTH-1:0]  wdata_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign wdata_arr[gi] = wdata_in[gi*WIDTH +: WIDTH];
        end
    endgenerate

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .req    (req),
        .ptr    (ptr_reg),
        .valid  (pick_valid),
        .winner (pick_winner),
        .gnt    (pick_gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            ack_reg   <= '0;
            we_reg    <= 1'b0;
            wdata_reg <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            ack_reg   <= ack_next;
            we_reg    <= we_next;
            wdata_reg <= wdata_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        ack_next   = '0;
        we_next    = 1'b0;
        wdata_next = wdata_reg;
        count_next = count_reg;
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    ack_next   = pick_gnt;
                    we_next    = 1'b1;
                    wdata_next = wdata_arr[pick_winner];
                    // Pointer moves just past the winner so it has lowest priority next round.
                    if (pick_winner == PW'(NREQ - 1))
                        ptr_next = '0;
                    else
                        ptr_next = pick_winner + 1'b1;
                    count_next = count_reg + 1'b1;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                // Requests are ignored here; this enforces the two-cycle write spacing.
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign ack         = ack_reg;
    assign reg_we      = we_reg;
    assign reg_wdata   = wdata_reg;
    assign busy        = (state_reg == WRITE);
    assign write_count = count_reg;

endmodule : reg_write_arbiter

// File: tb/tb_reg_write_arbiter.sv
// Directed self-checking bench: arbiter driving a behavioural shared register, CNT_W=4 to exercise wrap.
module tb_reg_write_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata_in;
    logic [NREQ-1:0]       ack;
    logic                  reg_we;
    logic [WIDTH-1:0]      reg_wdata;
    logic                  busy;
    logic [CNT_W-1:0]      write_count;

    logic [WIDTH-1:0]      rdata = '0;
    int                    n_checks = 0;
    int                    n_errors = 0;
    int                    exp_count = 0;

    always #5 clk = ~clk;

    reg_write_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .wdata_in    (wdata_in),
        .ack         (ack),
        .reg_we      (reg_we),
        .reg_wdata   (reg_wdata),
        .busy        (busy),
        .write_count (write_count)
    );

    // Shared 32-bit register
    always_ff @(posedge clk) begin
        if (reg_we) rdata <= reg_wdata;
    end

    task automatic check_eq(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic set_data(input int idx, input logic [WIDTH-1:0] d);
        wdata_in[idx*WIDTH +: WIDTH] = d;
    endtask

    // Waits for the next grant, expects it one cycle after the current sampling point,
    // then checks the idle cycle that follows and the value the register captured.
    task automatic serve(input int idx, input logic [WIDTH-1:0] d, input logic drop);
        int waited;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (ack == '0 && waited < 8);
        check_eq("grant_latency", 64'(waited), 64'd1);
        check_eq("ack", 64'(ack), 64'(4'b0001 << idx));
        check_eq("reg_we", 64'(reg_we), 64'd1);
        check_eq("busy", 64'(busy), 64'd1);
        check_eq("reg_wdata", 64'(reg_wdata), 64'(d));
        exp_count++;
        check_eq("write_count", 64'(write_count), 64'(exp_count % 16));
        $display("write: req %0d data 0x%08h count %0d", idx, reg_wdata, write_count);
        if (drop) req[idx] = 1'b0;
        @(negedge clk);
        check_eq("ack_clear", 64'(ack), 64'd0);
        check_eq("we_clear", 64'(reg_we), 64'd0);
        check_eq("busy_clear", 64'(busy), 64'd0);
        check_eq("rdata", 64'(rdata), 64'(d));
    endtask

    initial begin
        // Reset with all four requesting; nothing may be granted while rst is high
        rst = 1'b1;
        req = 4'b1111;
        wdata_in = '0;
        for (int i = 0; i < NREQ; i++) set_data(i, 32'(i + 1));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq("rst_ack", 64'(ack), 64'd0);
            check_eq("rst_we", 64'(reg_we), 64'd0);
            check_eq("rst_count", 64'(write_count), 64'd0);
        end
        check_eq("rst_wdata", 64'(reg_wdata), 64'd0);
        rst = 1'b0;

        // Full contention: served 0,1,2,3 two cycles apart
        for (int i = 0; i < NREQ; i++) serve(i, 32'(i + 1), 1'b1);
        check_eq("contention_rdata", 64'(rdata), 64'h4);

        // Single requester 2 (ptr wrapped back to 0)
        set_data(2, 32'hFFFF_0000);
        req = 4'b0100;
        serve(2, 32'hFFFF_0000, 1'b1);

        // Fairness: ptr is 3, requester 0 wins and stays requesting, then 3 must be served before 0 again
        set_data(0, 32'h0000_00A0);
        set_data(3, 32'h0000_00D3);
        req = 4'b0001;
        serve(0, 32'h0000_00A0, 1'b0);
        req[3] = 1'b1;
        serve(3, 32'h0000_00D3, 1'b1);
        serve(0, 32'h0000_00A0, 1'b1);

        // Reset during the ack cycle
        set_data(1, 32'h0000_00B1);
        req = 4'b0010;
        @(negedge clk);
        check_eq("pre_rst_ack", 64'(ack), 64'b0010);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_ack", 64'(ack), 64'd0);
        check_eq("midrst_we", 64'(reg_we), 64'd0);
        check_eq("midrst_busy", 64'(busy), 64'd0);
        check_eq("midrst_wdata", 64'(reg_wdata), 64'd0);
        check_eq("midrst_count", 64'(write_count), 64'd0);
        rst = 1'b0;
        exp_count = 0;
        // Without ptr reset (ptr would be 2) requester 3 would win first
        req = 4'b1001;
        serve(0, 32'h0000_00A0, 1'b1);
        serve(3, 32'h0000_00D3, 1'b1);

        // Counter wrap with CNT_W=4: 17 writes read ...15, 0, 1
        rst = 1'b1;
        @(negedge clk);
        check_eq("wrap_rst_count", 64'(write_count), 64'd0);
        rst = 1'b0;
        exp_count = 0;
        req = 4'b0010;
        for (int i = 1; i <= 17; i++) begin
            set_data(1, 32'(i * 16'h0101));
            serve(1, 32'(i * 16'h0101), i == 17);
        end
        check_eq("wrap_final", 64'(write_count), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_reg_write_arbiter
